// File: rtl/sub_mat_seq_pkg.sv
// Shared types and helpers for the sequential matrix subtractor.
// Latency: n/a (package only).
// Backpressure: n/a. SUB_MAT_SAT_EN selects saturated (N_BITS) or exact (N_BITS+1) results.
package mat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Result width: saturating builds clamp back to the operand width,
  // otherwise one extra bit keeps the difference exact.
  function automatic int out_bits(input int n);
`ifdef SUB_MAT_SAT_EN
    return n;
`else
    return n + 1;
`endif
  endfunction

  // Largest positive value representable in n signed bits.
  function automatic logic signed [63:0] sat_max(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in n signed bits.
  function automatic logic signed [63:0] sat_min(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction

endpackage

// File: rtl/sub_mat_seq_if.sv
// Operand/result bundle between a requester and sub_mat_seq.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored while the block is busy.
interface sub_mat_seq_if
  import mat_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int N_BITS = 32
);
  localparam int OUT_BITS = out_bits(N_BITS);

  logic                       start;
  logic signed [N_BITS-1:0]   mat_a   [SIZE_A][SIZE_B];
  logic signed [N_BITS-1:0]   mat_b   [SIZE_A][SIZE_B];
  logic                       busy;
  logic                       done;
  logic signed [OUT_BITS-1:0] mat_out [SIZE_A][SIZE_B];
  logic                       saturated;

  modport master (output start, mat_a, mat_b,
                  input  busy, done, mat_out, saturated);
  modport slave  (input  start, mat_a, mat_b,
                  output busy, done, mat_out, saturated);
endinterface

// File: rtl/sub_mat_seq_elem.sv
// Single-element signed subtract with optional clamp to the operand range.
// Latency: combinational.
// Backpressure: none.
module sub_elem
  import mat_pkg::*;
#(
  parameter  int N_BITS   = 32,
  localparam int OUT_BITS = out_bits(N_BITS)
) (
  input  logic signed [N_BITS-1:0]   a_i,
  input  logic signed [N_BITS-1:0]   b_i,
  output logic signed [OUT_BITS-1:0] diff_o,
  output logic                       clamped_o
);
  // Sign-extend both operands by one bit so the difference never wraps.
  logic signed [N_BITS:0] exact;
  assign exact = $signed({a_i[N_BITS-1], a_i}) - $signed({b_i[N_BITS-1], b_i});

`ifdef SUB_MAT_SAT_EN
  localparam logic signed [63:0]     MAX64 = sat_max(N_BITS);
  localparam logic signed [63:0]     MIN64 = sat_min(N_BITS);
  localparam logic signed [N_BITS:0] MAX_V = MAX64[N_BITS:0];
  localparam logic signed [N_BITS:0] MIN_V = MIN64[N_BITS:0];

  // Clamp the exact difference into the N_BITS signed range.
  always_comb begin
    diff_o    = exact[N_BITS-1:0];
    clamped_o = 1'b0;
    if (exact > MAX_V) begin
      diff_o    = MAX_V[N_BITS-1:0];
      clamped_o = 1'b1;
    end else if (exact < MIN_V) begin
      diff_o    = MIN_V[N_BITS-1:0];
      clamped_o = 1'b1;
    end
  end
`else
  assign diff_o    = exact;
  assign clamped_o = 1'b0;
`endif

endmodule

// File: rtl/sub_mat_seq.sv
// Sequential element-wise matrix subtract out = A - B, one element per clock, row-major.
// Latency: SIZE_A*SIZE_B cycles after accept, then a one-cycle done pulse; idle again one cycle later.
// Backpressure: start honoured only in IDLE, never queued. Macro SUB_MAT_SAT_EN enables saturation.
module sub_mat_seq
  import mat_pkg::*;
#(
  parameter  int SIZE_A   = 8,
  parameter  int SIZE_B   = 8,
  parameter  int N_BITS   = 32,
  localparam int OUT_BITS = out_bits(N_BITS)
) (
  input  logic         clk,
  input  logic         reset,
  sub_mat_seq_if.slave bus
);
  localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(SIZE_A - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(SIZE_B - 1);

  sub_state_t                 state_q;
  logic [RW-1:0]              row_q, row_d;
  logic [CW-1:0]              col_q, col_d;
  logic                       last_col, last_elem;
  logic signed [N_BITS-1:0]   a_q   [SIZE_A][SIZE_B];
  logic signed [N_BITS-1:0]   b_q   [SIZE_A][SIZE_B];
  logic signed [OUT_BITS-1:0] out_q [SIZE_A][SIZE_B];
  logic                       busy_q, done_q, sat_q;
  logic signed [OUT_BITS-1:0] elem_diff;
  logic                       elem_clamped;

  // One shared subtractor, steered by the row/col walk.
  sub_elem #(.N_BITS(N_BITS)) u_elem (
    .a_i       (a_q[row_q][col_q]),
    .b_i       (b_q[row_q][col_q]),
    .diff_o    (elem_diff),
    .clamped_o (elem_clamped)
  );

  // Row-major walk: column wraps into the next row.
  always_comb begin
    last_col  = (col_q == COL_LAST);
    last_elem = last_col && (row_q == ROW_LAST);
    col_d     = last_col ? '0 : col_q + 1'b1;
    row_d     = last_col ? row_q + 1'b1 : row_q;
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      for (int r = 0; r < SIZE_A; r++) begin
        for (int c = 0; c < SIZE_B; c++) begin
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
          out_q[r][c] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.mat_a;
            b_q     <= bus.mat_b;
            row_q   <= '0;
            col_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          out_q[row_q][col_q] <= elem_diff;
          sat_q <= sat_q | elem_clamped;
          row_q <= row_d;
          col_q <= col_d;
          if (last_elem) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.saturated = sat_q;
  assign bus.mat_out   = out_q;

endmodule
